// File: rtl/reaction_seq_ctrl_pkg.sv
// Shared definitions for the reaction-time sequencer: FSM state encodings and
// default sizing of the millisecond response counter.
package reaction_seq_ctrl_pkg;

  localparam int unsigned CNT_W_DEF  = 14;
  localparam int unsigned MAX_MS_DEF = 9999;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_WAIT = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

endpackage

// File: rtl/btn_edge_det.sv
// Registered rising-edge detector for an already synchronized button level.
// History resets to 1 so a button held through reset yields no edge.
module btn_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  logic btn_q;
  logic rise_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      btn_q  <= 1'b1;
      rise_q <= 1'b0;
    end else begin
      btn_q  <= btn;
      rise_q <= btn & ~btn_q;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/reaction_seq_ctrl.sv
// Reaction-time sequencer: arms the countdown, waits for expiry, lights the LED
// and measures the response in ms until the stop button is pressed.
module reaction_seq_ctrl
  import reaction_seq_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned MAX_MS  = MAX_MS_DEF,
  parameter int unsigned ARM_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_1ms,
  input  logic             start_btn,
  input  logic             stop_btn,
  input  logic             timer_flag,
  output logic             timer_rst_n,
  output logic             led,
  output logic             busy,
  output logic [CNT_W-1:0] result_ms,
  output logic             result_valid,
  output logic             early_err,
  output logic             timeout
);

  localparam int unsigned ARM_W = (ARM_CYC > 1) ? $clog2(ARM_CYC) : 1;

  logic start_rise;
  logic stop_rise;

  btn_edge_det u_start_edge (
    .clk  (clk),
    .rst  (rst),
    .btn  (start_btn),
    .rise (start_rise)
  );

  btn_edge_det u_stop_edge (
    .clk  (clk),
    .rst  (rst),
    .btn  (stop_btn),
    .rise (stop_rise)
  );

  state_e             state_q, state_d;
  logic [ARM_W-1:0]   arm_cnt_q, arm_cnt_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   result_q, result_d;
  logic               valid_q, valid_d;
  logic               early_q, early_d;
  logic               timeout_q, timeout_d;
  logic               timer_rst_n_q, led_q, busy_q;

  always_comb begin
    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    count_d   = count_q;
    result_d  = result_q;
    valid_d   = 1'b0;
    early_d   = early_q;
    timeout_d = timeout_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_rise) begin
          state_d   = ST_ARM;
          arm_cnt_d = '0;
          count_d   = '0;
          early_d   = 1'b0;
          timeout_d = 1'b0;
        end
      end
      ST_ARM: begin
        if (arm_cnt_q == ARM_W'(ARM_CYC - 1)) begin
          state_d = ST_WAIT;
        end else begin
          arm_cnt_d = arm_cnt_q + ARM_W'(1);
        end
      end
      ST_WAIT: begin
        // A press before expiry takes priority over a simultaneous expiry.
        if (stop_rise) begin
          state_d = ST_ERR;
          early_d = 1'b1;
        end else if (timer_flag) begin
          state_d = ST_RUN;
          count_d = '0;
        end
      end
      ST_RUN: begin
        if (stop_rise) begin
          state_d  = ST_DONE;
          result_d = count_q;
          valid_d  = 1'b1;
        end else if (tick_1ms) begin
          if (count_q >= CNT_W'(MAX_MS - 1)) begin
            state_d   = ST_DONE;
            count_d   = CNT_W'(MAX_MS);
            result_d  = CNT_W'(MAX_MS);
            timeout_d = 1'b1;
            valid_d   = 1'b1;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      arm_cnt_q     <= '0;
      count_q       <= '0;
      result_q      <= '0;
      valid_q       <= 1'b0;
      early_q       <= 1'b0;
      timeout_q     <= 1'b0;
      timer_rst_n_q <= 1'b0;
      led_q         <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      arm_cnt_q     <= arm_cnt_d;
      count_q       <= count_d;
      result_q      <= result_d;
      valid_q       <= valid_d;
      early_q       <= early_d;
      timeout_q     <= timeout_d;
      // Decoded from next state so the outputs line up with the state register.
      timer_rst_n_q <= (state_d == ST_WAIT) || (state_d == ST_RUN);
      led_q         <= (state_d == ST_RUN);
      busy_q        <= (state_d == ST_ARM) || (state_d == ST_WAIT) || (state_d == ST_RUN);
    end
  end

  assign timer_rst_n  = timer_rst_n_q;
  assign led          = led_q;
  assign busy         = busy_q;
  assign result_ms    = result_q;
  assign result_valid = valid_q;
  assign early_err    = early_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_reaction_seq_ctrl.sv
// Scoreboard bench: two instances (default limit and MAX_MS=20) share stimulus;
// expected results are queued per instance and popped by a negedge monitor.
module tb_reaction_seq_ctrl;

  typedef struct {
    bit          is_err;
    int unsigned ms;
    bit          to;
  } ev_t;

  logic clk = 1'b0;
  logic rst, tick_1ms, start_btn, stop_btn, timer_flag;

  logic        timer_rst_n, led, busy, result_valid, early_err, timeout;
  logic [13:0] result_ms;
  logic        timer_rst_n_s, led_s, busy_s, result_valid_s, early_err_s, timeout_s;
  logic [13:0] result_ms_s;

  int n_chk  = 0;
  int n_fail = 0;
  ev_t q0[$];
  ev_t q1[$];
  bit rv_p0 = 0, rv_p1 = 0, ee_p0 = 0, ee_p1 = 0;

  always #5 clk = ~clk;

  reaction_seq_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .tick_1ms     (tick_1ms),
    .start_btn    (start_btn),
    .stop_btn     (stop_btn),
    .timer_flag   (timer_flag),
    .timer_rst_n  (timer_rst_n),
    .led          (led),
    .busy         (busy),
    .result_ms    (result_ms),
    .result_valid (result_valid),
    .early_err    (early_err),
    .timeout      (timeout)
  );

  reaction_seq_ctrl #(.MAX_MS(20)) dut_sat (
    .clk          (clk),
    .rst          (rst),
    .tick_1ms     (tick_1ms),
    .start_btn    (start_btn),
    .stop_btn     (stop_btn),
    .timer_flag   (timer_flag),
    .timer_rst_n  (timer_rst_n_s),
    .led          (led_s),
    .busy         (busy_s),
    .result_ms    (result_ms_s),
    .result_valid (result_valid_s),
    .early_err    (early_err_s),
    .timeout      (timeout_s)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_res(input int which, input int unsigned ms, input bit to);
    ev_t e;
    e.is_err = 1'b0;
    e.ms     = ms;
    e.to     = to;
    if (which == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic push_err();
    ev_t e;
    e.is_err = 1'b1;
    e.ms     = 0;
    e.to     = 1'b0;
    q0.push_back(e);
    q1.push_back(e);
  endtask

  task automatic mon(input int which, input logic rv, input bit rv_p, input logic ee,
                     input bit ee_p, input logic [13:0] ms, input logic to);
    ev_t e;
    bit  empty;
    if (rv) chk($sformatf("valid_one_cycle[%0d]", which), {31'd0, rv_p}, 32'd0);
    if (rv === 1'b1 || (ee === 1'b1 && !ee_p)) begin
      empty = 1'b0;
      if (which == 0) begin
        if (q0.size() == 0) empty = 1'b1;
        else e = q0.pop_front();
      end else begin
        if (q1.size() == 0) empty = 1'b1;
        else e = q1.pop_front();
      end
      if (empty) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_event[%0d]: got rv=%0d ms=%0d, expected no event",
                 which, rv, ms);
      end else begin
        chk($sformatf("event_is_err[%0d]", which), {31'd0, ~rv}, {31'd0, e.is_err});
        if (!e.is_err) begin
          chk($sformatf("result_ms[%0d]", which), {18'd0, ms}, e.ms);
          chk($sformatf("timeout_flag[%0d]", which), {31'd0, to}, {31'd0, e.to});
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, result_valid, rv_p0, early_err, ee_p0, result_ms, timeout);
    mon(1, result_valid_s, rv_p1, early_err_s, ee_p1, result_ms_s, timeout_s);
    rv_p0 = (result_valid === 1'b1);
    rv_p1 = (result_valid_s === 1'b1);
    ee_p0 = (early_err === 1'b1);
    ee_p1 = (early_err_s === 1'b1);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_start();
    start_btn = 1'b1;
    cyc(1);
    start_btn = 1'b0;
  endtask

  // Press start and follow the ARM phase into WAIT, counting ARM cycles.
  task automatic arm_to_wait();
    int arm_lo;
    arm_lo = 0;
    press_start();
    for (int i = 0; i < 20; i++) begin
      if (timer_rst_n === 1'b1) break;
      if (busy === 1'b1 && timer_rst_n === 1'b0) arm_lo++;
      cyc(1);
    end
    chk("reach_wait", timer_rst_n, 1);
    chk("arm_low_cycles", arm_lo, 2);
    chk("wait_led_off", led, 0);
    chk("wait_early_cleared", early_err, 0);
    chk("wait_timeout_cleared", timeout, 0);
  endtask

  task automatic flag_to_run();
    cyc(5);
    timer_flag = 1'b1;
    cyc(1);
    chk("run_led_on", led, 1);
    chk("run_busy", busy, 1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1ms = 1'b1;
      cyc(1);
      tick_1ms = 1'b0;
      cyc(1);
    end
  endtask

  task automatic press_stop(input bit with_tick);
    stop_btn = 1'b1;
    cyc(1);
    stop_btn = 1'b0;
    tick_1ms = with_tick;
    cyc(1);
    tick_1ms = 1'b0;
    cyc(1);
    timer_flag = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; start_btn = 1'b1; stop_btn = 1'b0; tick_1ms = 1'b0; timer_flag = 1'b0;
    cyc(3);
    chk("rst_timer_rst_n", timer_rst_n, 0);
    chk("rst_led", led, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result_ms", result_ms, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_early_err", early_err, 0);
    chk("rst_timeout", timeout, 0);
    rst = 1'b1;
    cyc(4);
    chk("held_start_no_arm", busy, 0);
    chk("held_start_no_arm_sat", busy_s, 0);
    start_btn = 1'b0;
    cyc(2);

    // Reset while running at count 10: abort, no result.
    arm_to_wait();
    flag_to_run();
    ticks(10);
    rst = 1'b0;
    cyc(1);
    chk("abort_busy", busy, 0);
    chk("abort_led", led, 0);
    chk("abort_timer_rst_n", timer_rst_n, 0);
    chk("abort_result_ms", result_ms, 0);
    chk("abort_busy_sat", busy_s, 0);
    rst = 1'b1;
    timer_flag = 1'b0;
    cyc(2);

    // Normal run of 137 ticks; limited instance saturates at 20.
    push_res(0, 137, 0);
    push_res(1, 20, 1);
    arm_to_wait();
    flag_to_run();
    ticks(137);
    chk("run_led_still_on", led, 1);
    press_stop(0);
    chk("done_led_off", led, 0);
    chk("done_busy", busy, 0);
    chk("done_timer_rst_n", timer_rst_n, 0);
    cyc(2);

    // Early press in WAIT, then press coincident with expiry.
    push_err();
    arm_to_wait();
    cyc(3);
    press_stop(0);
    chk("early_err_set", early_err, 1);
    chk("early_led_off", led, 0);
    push_err();
    arm_to_wait();
    cyc(3);
    stop_btn = 1'b1;
    cyc(1);
    stop_btn = 1'b0;
    timer_flag = 1'b1;
    cyc(1);
    timer_flag = 1'b0;
    cyc(1);
    chk("early_vs_flag_err", early_err, 1);
    chk("early_vs_flag_led", led, 0);
    chk("early_vs_flag_busy", busy, 0);
    cyc(2);

    // Stop coincident with a tick at count 42: the tick is not counted.
    push_res(0, 42, 0);
    push_res(1, 20, 1);
    arm_to_wait();
    flag_to_run();
    ticks(42);
    press_stop(1);
    chk("tick_stop_result", result_ms, 42);
    cyc(2);

    // Saturation without a stop on the limited instance.
    push_res(1, 20, 1);
    push_res(0, 20, 0);
    arm_to_wait();
    flag_to_run();
    ticks(20);
    chk("sat_timeout", timeout_s, 1);
    chk("sat_result", result_ms_s, 20);
    chk("sat_led_off", led_s, 0);
    chk("sat_busy", busy_s, 0);
    chk("nosat_led_on", led, 1);
    press_stop(0);
    chk("nosat_timeout", timeout, 0);
    cyc(2);

    // Stop and saturating tick in the same cycle: stop wins.
    push_res(0, 19, 0);
    push_res(1, 19, 0);
    arm_to_wait();
    flag_to_run();
    ticks(19);
    press_stop(1);
    chk("stop_sat_timeout", timeout_s, 0);
    chk("stop_sat_result", result_ms_s, 19);
    cyc(5);

    chk("queue_drained", q0.size(), 0);
    chk("queue_drained_sat", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
